alu_issuer: RTL and testbench

- Initiator side of the 4-bit ALU operand/result interface.
- Debounces a board push-button, then latches switch operands and opcode onto registered ALU inputs (alu_a, alu_b, alu_ctrl).
- Waits a fixed settle window, captures the ALU's res/car/of, and pushes each result into a small history ring.
- The board readout (7-seg, LEDs) consumes the history ring.

---
 rtl/alu_issuer.sv | 213 +++++++++++++++++++++
 tb/tb_alu_issuer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issuer.sv
// Issues switch operands to a 4-bit ALU on a debounced button press, captures the result after a
// settle window and keeps a small history ring. Optional self-check model: ALU_SELFCHECK_EN.
module alu_issuer #(
  parameter int unsigned SETTLE    = 2,
  parameter int unsigned DB_CYCLES = 4,
  parameter int unsigned DEPTH     = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [3:0]                 sw_a,
  input  logic [3:0]                 sw_b,
  input  logic [2:0]                 sw_op,
  input  logic                       btn_go,
  input  logic                       btn_clr,
  output logic [3:0]                 alu_a,
  output logic [3:0]                 alu_b,
  output logic [2:0]                 alu_ctrl,
  input  logic [3:0]                 alu_res,
  input  logic                       alu_car,
  input  logic                       alu_of,
  output logic                       busy,
  output logic                       done,
  output logic [3:0]                 res_q,
  output logic [1:0]                 flags_q,
  output logic [$clog2(DEPTH):0]     hist_cnt,
  input  logic [$clog2(DEPTH)-1:0]   hist_sel,
  output logic [5:0]                 hist_out,
  output logic                       err
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned SCW = $clog2(SETTLE) + 1;
  localparam int unsigned DCW = $clog2(DB_CYCLES) + 1;
  localparam logic [SCW-1:0] SettleLast = SCW'(SETTLE - 1);
  localparam logic [DCW-1:0] DbLast     = DCW'(DB_CYCLES - 1);
  localparam logic [AW:0]    CntFull    = (AW + 1)'(DEPTH);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StSettle  = 2'd1;
  localparam logic [1:0] StCapture = 2'd2;
  localparam logic [1:0] StDone    = 2'd3;

  logic           sync1_q, sync2_q, db_lvl_q, db_prev_q;
  logic [DCW-1:0] db_cnt_q;
  logic           go_pulse;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      db_lvl_q  <= 1'b0;
      db_prev_q <= 1'b0;
      db_cnt_q  <= '0;
    end else begin
      sync1_q   <= btn_go;
      sync2_q   <= sync1_q;
      db_prev_q <= db_lvl_q;
      if (sync2_q == db_lvl_q) begin
        db_cnt_q <= '0;
      end else if (db_cnt_q == DbLast) begin
        db_lvl_q <= ~db_lvl_q;
        db_cnt_q <= '0;
      end else begin
        db_cnt_q <= db_cnt_q + 1'b1;
      end
    end
  end

  assign go_pulse = db_lvl_q & ~db_prev_q;

  logic [1:0]     state_q, state_d;
  logic [SCW-1:0] set_cnt_q, set_cnt_d;
  logic [3:0]     alu_a_q, alu_a_d, alu_b_q, alu_b_d, cap_res_q, cap_res_d;
  logic [2:0]     alu_ctrl_q, alu_ctrl_d;
  logic [1:0]     cap_flags_q, cap_flags_d;
  logic [AW:0]    hist_cnt_q, hist_cnt_d;
  logic [AW-1:0]  wptr_q, wptr_d, rd_idx;
  logic [5:0]     ring_q [DEPTH];

  always_comb begin
    state_d     = state_q;
    set_cnt_d   = set_cnt_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_ctrl_d  = alu_ctrl_q;
    cap_res_d   = cap_res_q;
    cap_flags_d = cap_flags_q;
    hist_cnt_d  = hist_cnt_q;
    wptr_d      = wptr_q;
    case (state_q)
      StIdle: begin
        if (btn_clr) begin
          hist_cnt_d  = '0;
          wptr_d      = '0;
          cap_res_d   = '0;
          cap_flags_d = '0;
        end
        if (go_pulse) begin
          alu_a_d    = sw_a;
          alu_b_d    = sw_b;
          alu_ctrl_d = sw_op;
          set_cnt_d  = '0;
          state_d    = StSettle;
        end
      end
      StSettle: begin
        if (set_cnt_q == SettleLast) state_d = StCapture;
        else set_cnt_d = set_cnt_q + 1'b1;
      end
      StCapture: begin
        cap_res_d   = alu_res;
        cap_flags_d = {alu_of, alu_car};
        wptr_d      = wptr_q + 1'b1;
        if (hist_cnt_q != CntFull) hist_cnt_d = hist_cnt_q + 1'b1;
        state_d     = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      set_cnt_q   <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_ctrl_q  <= '0;
      cap_res_q   <= '0;
      cap_flags_q <= '0;
      hist_cnt_q  <= '0;
      wptr_q      <= '0;
    end else begin
      state_q     <= state_d;
      set_cnt_q   <= set_cnt_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_ctrl_q  <= alu_ctrl_d;
      cap_res_q   <= cap_res_d;
      cap_flags_q <= cap_flags_d;
      hist_cnt_q  <= hist_cnt_d;
      wptr_q      <= wptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) ring_q[i] <= '0;
    end else if (state_q == StCapture) begin
      ring_q[wptr_q] <= {alu_of, alu_car, alu_res};
    end
  end

  // Newest entry sits just behind the write pointer.
  assign rd_idx   = wptr_q - AW'(1) - hist_sel;
  assign hist_out = ({1'b0, hist_sel} < hist_cnt_q) ? ring_q[rd_idx] : 6'd0;

  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign alu_ctrl = alu_ctrl_q;
  assign res_q    = cap_res_q;
  assign flags_q  = cap_flags_q;
  assign hist_cnt = hist_cnt_q;
  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StDone);

`ifdef ALU_SELFCHECK_EN
  logic [4:0] sum;
  logic [3:0] neg_b, exp_res;
  logic       exp_car, exp_of, err_q;

  always_comb begin
    neg_b   = (~alu_b_q) + 4'd1;
    sum     = '0;
    exp_res = '0;
    exp_car = 1'b0;
    exp_of  = 1'b0;
    case (alu_ctrl_q)
      3'b000, 3'b001: begin
        sum     = {1'b0, alu_a_q} + {1'b0, (alu_ctrl_q[0] ? neg_b : alu_b_q)};
        exp_res = sum[3:0];
        exp_car = sum[4];
        exp_of  = (alu_a_q[3] == alu_b_q[3]) && (sum[3] != alu_a_q[3]);
      end
      3'b010: exp_res = ~alu_a_q;
      3'b011: exp_res = alu_a_q & alu_b_q;
      3'b100: exp_res = alu_a_q | alu_b_q;
      3'b101: exp_res = alu_a_q ^ alu_b_q;
      3'b110: begin
        if (!alu_a_q[3] && alu_b_q[3])      exp_res = 4'd0;
        else if (alu_a_q[3] && !alu_b_q[3]) exp_res = 4'd1;
        else                                exp_res = (alu_a_q < alu_b_q) ? 4'd0 : 4'd1;
      end
      default: exp_res = (alu_a_q == alu_b_q) ? 4'd0 : 4'd1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (state_q == StIdle && btn_clr) begin
      err_q <= 1'b0;
    end else if (state_q == StCapture &&
                 {exp_of, exp_car, exp_res} != {alu_of, alu_car, alu_res}) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_issuer.sv
// Bench for alu_issuer: behavioural ALU responder plus a queue model of the history ring.
module tb_alu_issuer;
  localparam int unsigned S     = 16;
  localparam int unsigned DB    = 4;
  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n, btn_go, btn_clr, alu_car, alu_of, busy, done, err;
  logic [3:0] sw_a, sw_b, alu_a, alu_b, alu_res, res_q;
  logic [2:0] sw_op, alu_ctrl;
  logic [1:0] flags_q, hist_sel;
  logic [2:0] hist_cnt;
  logic [5:0] hist_out;
  logic       force_bad = 1'b0;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  logic [5:0] hist_m [$];

  alu_issuer #(.SETTLE(S), .DB_CYCLES(DB), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .sw_a(sw_a), .sw_b(sw_b), .sw_op(sw_op), .btn_go(btn_go),
    .btn_clr(btn_clr), .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_res(alu_res),
    .alu_car(alu_car), .alu_of(alu_of), .busy(busy), .done(done), .res_q(res_q),
    .flags_q(flags_q), .hist_cnt(hist_cnt), .hist_sel(hist_sel), .hist_out(hist_out), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference ALU in plain integer arithmetic; returns {of, car, res}.
  function automatic logic [5:0] alu_ref(input logic [3:0] a, input logic [3:0] b,
                                         input logic [2:0] op);
    int ai, bi, s;
    logic [3:0] r;
    logic c, o;
    ai = int'(a); bi = int'(b); c = 1'b0; o = 1'b0;
    case (op)
      3'd0, 3'd1: begin
        s = ai + ((op == 3'd0) ? bi : (16 - bi) % 16);
        r = 4'(s % 16);
        c = (s > 15);
        o = (a[3] == b[3]) && (r[3] != a[3]);
      end
      3'd2: r = 4'(15 - ai);
      3'd3: r = a & b;
      3'd4: r = a | b;
      3'd5: r = a ^ b;
      3'd6: r = (ai >= bi) ? 4'd1 : 4'd0;
      default: r = (ai == bi) ? 4'd0 : 4'd1;
    endcase
    return {o, c, r};
  endfunction

  always_comb begin
    {alu_of, alu_car, alu_res} = alu_ref(alu_a, alu_b, alu_ctrl);
    if (force_bad) alu_res = 4'h4;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_push(input logic [5:0] e);
    hist_m.push_front(e);
    if (hist_m.size() > DEPTH) void'(hist_m.pop_back());
  endtask

  // Press for 29 cycles then release; btn_clr is pulsed for the cycle press+clr_at.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                        input int clr_at, output int ndone, output int done_at,
                        output int press_at);
    sw_a = a; sw_b = b; sw_op = op; btn_go = 1'b1;
    press_at = cyc; ndone = 0; done_at = -1;
    for (int i = 1; i <= 60; i++) begin
      if (i == 30) btn_go = 1'b0;
      step();
      btn_clr = (i == clr_at);
      if (done) begin ndone++; done_at = cyc; end
    end
    btn_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    hist_sel = 2'd0;
    #1;
    checks++; if (alu_a !== 4'd0) begin errors++; $display("FAIL reset_alu_a got %0h want 0", alu_a); end
    checks++; if (alu_b !== 4'd0) begin errors++; $display("FAIL reset_alu_b got %0h want 0", alu_b); end
    checks++; if (alu_ctrl !== 3'd0) begin errors++; $display("FAIL reset_alu_ctrl got %0h want 0", alu_ctrl); end
    checks++; if ({busy, done, err} !== 3'b000) begin errors++; $display("FAIL reset_busy_done_err got %b want 000", {busy, done, err}); end
    checks++; if ({res_q, flags_q} !== 6'd0) begin errors++; $display("FAIL reset_res_flags got %0h want 0", {res_q, flags_q}); end
    checks++; if (hist_cnt !== 3'd0) begin errors++; $display("FAIL reset_hist_cnt got %0d want 0", hist_cnt); end
    checks++; if (hist_out !== 6'd0) begin errors++; $display("FAIL reset_hist_out got %0h want 0", hist_out); end
    rst_n = 1'b1;
    step();
    hist_m.delete();
  endtask

  task automatic test_basic();
    int nd, dat, pat;
    run_op(4'd3, 4'd5, 3'd0, 0, nd, dat, pat);
    model_push(alu_ref(4'd3, 4'd5, 3'd0));
    checks++; if (nd !== 1) begin errors++; $display("FAIL basic_done_count got %0d want 1", nd); end
    checks++; if (dat !== pat + 2 + int'(DB) + int'(S) + 2) begin errors++; $display("FAIL basic_done_latency got %0d want %0d", dat - pat, 2 + DB + S + 2); end
    checks++; if (res_q !== 4'd8) begin errors++; $display("FAIL basic_res got %0h want 8", res_q); end
    checks++; if (flags_q !== 2'b10) begin errors++; $display("FAIL basic_flags got %b want 10", flags_q); end
    checks++; if (hist_cnt !== 3'd1) begin errors++; $display("FAIL basic_hist_cnt got %0d want 1", hist_cnt); end
    checks++; if (alu_a !== 4'd3) begin errors++; $display("FAIL basic_alu_a_hold got %0h want 3", alu_a); end
    hist_sel = 2'd0; #1;
    checks++; if (hist_out !== 6'b10_1000) begin errors++; $display("FAIL basic_hist_out got %0h want 28", hist_out); end
  endtask

  task automatic test_bounce();
    logic [2:0] cnt0;
    logic saw_busy;
    cnt0 = hist_cnt; saw_busy = 1'b0;
    for (int i = 0; i < 12; i++) begin
      btn_go = ~btn_go;
      step();
      saw_busy |= busy;
    end
    btn_go = 1'b0;
    for (int i = 0; i < 20; i++) begin step(); saw_busy |= busy; end
    checks++; if (saw_busy !== 1'b0) begin errors++; $display("FAIL bounce_busy got %b want 0", saw_busy); end
    checks++; if (hist_cnt !== cnt0) begin errors++; $display("FAIL bounce_hist_cnt got %0d want %0d", hist_cnt, cnt0); end
  endtask

  task automatic test_drop();
    int nd;
    logic busy_at_2nd;
    logic [2:0] cnt0;
    cnt0 = hist_cnt; nd = 0; busy_at_2nd = 1'b0;
    sw_a = 4'd1; sw_b = 4'd2; sw_op = 3'd0; btn_go = 1'b1;
    for (int i = 1; i <= 70; i++) begin
      if (i == 9) begin btn_go = 1'b0; sw_a = 4'd9; end
      if (i == 17) btn_go = 1'b1;
      if (i == 25) btn_go = 1'b0;
      step();
      if (i == 22) busy_at_2nd = busy;
      if (done) nd++;
    end
    model_push(alu_ref(4'd1, 4'd2, 3'd0));
    checks++; if (busy_at_2nd !== 1'b1) begin errors++; $display("FAIL drop_second_press_busy got %b want 1", busy_at_2nd); end
    checks++; if (nd !== 1) begin errors++; $display("FAIL drop_done_count got %0d want 1", nd); end
    checks++; if (alu_a !== 4'd1) begin errors++; $display("FAIL drop_alu_a got %0h want 1", alu_a); end
    checks++; if (hist_cnt !== cnt0 + 3'd1) begin errors++; $display("FAIL drop_hist_cnt got %0d want %0d", hist_cnt, cnt0 + 3'd1); end
  endtask

  task automatic test_clear();
    int nd, dat, pat;
    btn_clr = 1'b1; step(); btn_clr = 1'b0;
    hist_m.delete();
    hist_sel = 2'd0; #1;
    checks++; if (hist_cnt !== 3'd0) begin errors++; $display("FAIL clr_idle_cnt got %0d want 0", hist_cnt); end
    checks++; if (hist_out !== 6'd0) begin errors++; $display("FAIL clr_idle_hist_out got %0h want 0", hist_out); end
    checks++; if ({res_q, flags_q} !== 6'd0) begin errors++; $display("FAIL clr_idle_res got %0h want 0", {res_q, flags_q}); end
    // Clear pulse lands in SETTLE and must be ignored.
    run_op(4'd6, 4'd3, 3'd5, 10, nd, dat, pat);
    model_push(alu_ref(4'd6, 4'd3, 3'd5));
    #1;
    checks++; if (hist_cnt !== 3'd1) begin errors++; $display("FAIL clr_busy_cnt got %0d want 1", hist_cnt); end
    checks++; if (hist_out !== hist_m[0]) begin errors++; $display("FAIL clr_busy_entry got %0h want %0h", hist_out, hist_m[0]); end
    run_op(4'd2, 4'd2, 3'd7, 0, nd, dat, pat);
    model_push(alu_ref(4'd2, 4'd2, 3'd7));
    // Clear pulse coincides with the go cycle: clear, then the issue proceeds.
    run_op(4'd9, 4'd4, 3'd6, 2 + int'(DB), nd, dat, pat);
    hist_m.delete();
    model_push(alu_ref(4'd9, 4'd4, 3'd6));
    hist_sel = 2'd0; #1;
    checks++; if (nd !== 1) begin errors++; $display("FAIL clr_go_done got %0d want 1", nd); end
    checks++; if (hist_cnt !== 3'd1) begin errors++; $display("FAIL clr_go_cnt got %0d want 1", hist_cnt); end
    checks++; if (hist_out !== hist_m[0]) begin errors++; $display("FAIL clr_go_entry got %0h want %0h", hist_out, hist_m[0]); end
    hist_sel = 2'd1; #1;
    checks++; if (hist_out !== 6'd0) begin errors++; $display("FAIL clr_go_old_entry got %0h want 0", hist_out); end
  endtask

  task automatic test_depth();
    int nd, dat, pat;
    btn_clr = 1'b1; step(); btn_clr = 1'b0;
    hist_m.delete();
    for (int b = 1; b <= 5; b++) begin
      run_op(4'hF, 4'(b), 3'd3, 0, nd, dat, pat);
      model_push(alu_ref(4'hF, 4'(b), 3'd3));
    end
    checks++; if (hist_cnt !== 3'd4) begin errors++; $display("FAIL depth_cnt got %0d want 4", hist_cnt); end
    hist_sel = 2'd0; #1;
    checks++; if (hist_out[3:0] !== 4'd5) begin errors++; $display("FAIL depth_sel0 got %0h want 5", hist_out[3:0]); end
    hist_sel = 2'd3; #1;
    checks++; if (hist_out[3:0] !== 4'd2) begin errors++; $display("FAIL depth_sel3 got %0h want 2", hist_out[3:0]); end
  endtask

  task automatic test_random();
    int nd, dat, pat;
    logic [3:0] a, b;
    logic [2:0] op;
    for (int n = 0; n < 8; n++) begin
      a = 4'($urandom_range(0, 15)); b = 4'($urandom_range(0, 15)); op = 3'($urandom_range(0, 7));
      run_op(a, b, op, 0, nd, dat, pat);
      model_push(alu_ref(a, b, op));
      checks++; if ({nd == 1, flags_q, res_q} !== {1'b1, hist_m[0]}) begin errors++; $display("FAIL rand_op%0d done=%0d got %0h want %0h", n, nd, {flags_q, res_q}, hist_m[0]); end
    end
    for (int s = 0; s < int'(DEPTH); s++) begin
      hist_sel = 2'(s); #1;
      checks++; if (hist_out !== ((s < hist_m.size()) ? hist_m[s] : 6'd0)) begin errors++; $display("FAIL rand_hist%0d got %0h want %0h", s, hist_out, (s < hist_m.size()) ? hist_m[s] : 6'd0); end
    end
    checks++; if (int'(hist_cnt) !== hist_m.size()) begin errors++; $display("FAIL rand_cnt got %0d want %0d", hist_cnt, hist_m.size()); end
  endtask

  task automatic test_selfcheck();
    int nd, dat, pat;
`ifdef ALU_SELFCHECK_EN
    run_op(4'd7, 4'd2, 3'd1, 0, nd, dat, pat);
    checks++; if ({flags_q, res_q} !== 6'b01_0101) begin errors++; $display("FAIL sc_good_result got %0h want 15", {flags_q, res_q}); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL sc_good_err got %b want 0", err); end
    force_bad = 1'b1;
    run_op(4'd7, 4'd2, 3'd1, 0, nd, dat, pat);
    force_bad = 1'b0;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL sc_bad_err got %b want 1", err); end
    btn_clr = 1'b1; step(); btn_clr = 1'b0;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL sc_clr_err got %b want 0", err); end
`else
    force_bad = 1'b1;
    run_op(4'd7, 4'd2, 3'd1, 0, nd, dat, pat);
    force_bad = 1'b0;
    checks++; if (res_q !== 4'd4) begin errors++; $display("FAIL sc_off_res got %0h want 4", res_q); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL sc_off_err got %b want 0", err); end
`endif
  endtask

  initial begin
    rst_n = 1'b0; btn_go = 1'b0; btn_clr = 1'b0;
    sw_a = '0; sw_b = '0; sw_op = '0; hist_sel = '0;
    test_reset();
    test_basic();
    test_bounce();
    test_drop();
    test_clear();
    test_depth();
    test_random();
    test_selfcheck();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
